// File: rtl/csa_accum.sv
// Carry-save multi-operand accumulator: one 4:2 compression per accepted beat, then a final add.
// Define CSA_ACCUM_SPLIT_EN for a two-cycle split final add (DW must be even).
module csa_accum #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          start,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_sum,
    output logic [CW-1:0] out_count,
    output logic          busy
);

    typedef enum logic [2:0] {StIdle, StAccum, StResolve, StResolveHi, StDone} state_e;

    state_e        state_q;
    logic [DW-1:0] sum_q;
    logic [DW-1:0] carry_q;
    logic [CW-1:0] count_q;
    logic [DW-1:0] res_q;

    logic [DW-1:0] fa1_s, fa1_co, fa2_cin, csa_sum, csa_carry;
    logic [CW-1:0] count_inc;

    // Two chained full-adder rows; the first row's carries ripple one bit into the second row.
    always_comb begin
        fa1_s     = sum_q ^ carry_q ^ in_a;
        fa1_co    = (sum_q & carry_q) | (sum_q & in_a) | (carry_q & in_a);
        fa2_cin   = fa1_co << 1;
        csa_sum   = fa1_s ^ in_b ^ fa2_cin;
        csa_carry = (fa1_s & in_b) | (fa1_s & fa2_cin) | (in_b & fa2_cin);
        count_inc = (count_q == {CW{1'b1}}) ? count_q : count_q + {{(CW-1){1'b0}}, 1'b1};
    end

`ifdef CSA_ACCUM_SPLIT_EN
    localparam int unsigned H = DW / 2;
    logic         half_c_q;
    logic [H:0]   lo_add;
    logic [H-1:0] hi_add;

    always_comb begin
        lo_add = {1'b0, sum_q[H-1:0]} + {1'b0, carry_q[H-1:0]};
        hi_add = sum_q[DW-1:H] + carry_q[DW-1:H] + {{(H-1){1'b0}}, half_c_q};
    end
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= StIdle;
            sum_q    <= '0;
            carry_q  <= '0;
            count_q  <= '0;
            res_q    <= '0;
`ifdef CSA_ACCUM_SPLIT_EN
            half_c_q <= 1'b0;
`endif
        end else if (clear) begin
            state_q  <= StIdle;
            sum_q    <= '0;
            carry_q  <= '0;
            count_q  <= '0;
            res_q    <= '0;
`ifdef CSA_ACCUM_SPLIT_EN
            half_c_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        sum_q   <= '0;
                        carry_q <= '0;
                        count_q <= '0;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    if (in_valid) begin
                        sum_q   <= csa_sum;
                        carry_q <= csa_carry << 1;
                        count_q <= count_inc;
                        if (in_last) state_q <= StResolve;
                    end
                end
                StResolve: begin
`ifdef CSA_ACCUM_SPLIT_EN
                    res_q[H-1:0] <= lo_add[H-1:0];
                    half_c_q     <= lo_add[H];
                    state_q      <= StResolveHi;
`else
                    res_q   <= sum_q + carry_q;
                    state_q <= StDone;
`endif
                end
                StResolveHi: begin
`ifdef CSA_ACCUM_SPLIT_EN
                    res_q[DW-1:H] <= hi_add;
                    state_q       <= StDone;
`else
                    state_q <= StIdle;
`endif
                end
                StDone: begin
                    if (out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        out_sum   = res_q;
        out_count = count_q;
    end

endmodule

// File: tb/tb_csa_accum.sv
// Directed bench for csa_accum: table of transactions plus backpressure, abort and reset sequences.
module tb_csa_accum;

`ifdef CSA_ACCUM_SPLIT_EN
    localparam int ExpLat = 2;
`else
    localparam int ExpLat = 1;
`endif

    logic       clk = 1'b0;
    logic       nreset, start, clear, in_valid, in_last, out_ready;
    logic [7:0] in_a, in_b;
    logic       in_ready, out_valid, busy;
    logic [7:0] out_sum, out_count;
    logic       in_ready2, out_valid2, busy2;
    logic [7:0] out_sum2;
    logic [1:0] out_count2;

    always #5 clk = ~clk;

    csa_accum #(.DW(8), .CW(8)) dut (
        .clk(clk), .nreset(nreset), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .busy(busy)
    );

    csa_accum #(.DW(8), .CW(2)) dut2 (
        .clk(clk), .nreset(nreset), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .out_sum(out_sum2), .out_count(out_count2), .busy(busy2)
    );

    typedef struct packed {
        logic [2:0]      n;
        logic [4:0][7:0] a;
        logic [4:0][7:0] b;
        logic [7:0]      sum;
        logic [7:0]      cnt;
        logic [1:0]      cnt2;
    } vec_t;

    vec_t tbl [6];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic begin_txn(input vec_t v);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("in_ready_after_start", in_ready, 1);
        for (int i = 0; i < int'(v.n); i++) begin
            in_valid = 1'b1;
            in_a     = v.a[i];
            in_b     = v.b[i];
            in_last  = (i == int'(v.n) - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_b     = '0;
    endtask

    task automatic wait_done(input vec_t v);
        int lat = 0;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        check("latency", lat, ExpLat);
        check("out_sum", out_sum, v.sum);
        check("out_count", out_count, v.cnt);
        check("out_sum_cw2", out_sum2, v.sum);
        check("out_count_cw2", out_count2, v.cnt2);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after_handshake", {busy, out_valid}, 0);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) tbl[i] = '0;
        tbl[0].n = 2; tbl[0].a[0] = 3;   tbl[0].b[0] = 5;   tbl[0].a[1] = 10; tbl[0].b[1] = 20;
        tbl[0].sum = 38; tbl[0].cnt = 2; tbl[0].cnt2 = 2;
        tbl[1].n = 1; tbl[1].a[0] = 200; tbl[1].b[0] = 100;
        tbl[1].sum = 44; tbl[1].cnt = 1; tbl[1].cnt2 = 1;
        tbl[2].n = 3; tbl[2].a[0] = 255; tbl[2].b[0] = 255; tbl[2].a[1] = 255; tbl[2].b[1] = 255;
        tbl[2].a[2] = 4; tbl[2].b[2] = 0;
        tbl[2].sum = 0; tbl[2].cnt = 3; tbl[2].cnt2 = 3;
        tbl[3].n = 5;
        for (int i = 0; i < 5; i++) begin
            tbl[3].a[i] = 1;
            tbl[3].b[i] = 1;
        end
        tbl[3].sum = 10; tbl[3].cnt = 5; tbl[3].cnt2 = 3;
        tbl[4].n = 1; tbl[4].a[0] = 7; tbl[4].b[0] = 0;
        tbl[4].sum = 7; tbl[4].cnt = 1; tbl[4].cnt2 = 1;
        tbl[5].n = 1; tbl[5].a[0] = 9; tbl[5].b[0] = 9;
        tbl[5].sum = 18; tbl[5].cnt = 1; tbl[5].cnt2 = 1;

        nreset = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_a = '0; in_b = '0;
        #2;
        check("reset_outputs", {in_ready, out_valid, busy, out_sum, out_count}, 0);
        #10;
        nreset = 1'b1;
        tick();

        for (int t = 0; t < 4; t++) begin
            begin_txn(tbl[t]);
            wait_done(tbl[t]);
            handshake();
        end

        // Backpressure: result must hold while start and in_valid toggle.
        begin_txn(tbl[0]);
        wait_done(tbl[0]);
        for (int i = 0; i < 5; i++) begin
            start    = 1'b1;
            in_valid = ~in_valid;
            in_a     = 8'd99;
            in_b     = 8'd1;
            tick();
            check("bp_hold", {out_valid, in_ready, out_sum, out_count}, {1'b1, 1'b0, 8'd38, 8'd2});
        end
        start    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        handshake();

        // Abort on the same cycle as the last beat.
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7;
        tick();
        in_a = 8'd1; in_b = 8'd1; in_last = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("abort_idle", {busy, in_ready, out_valid, out_count}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_valid", out_valid, 0);
        end
        begin_txn(tbl[4]);
        wait_done(tbl[4]);
        handshake();

        // Asynchronous reset in the middle of ACCUM.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 8'(i + 1); in_b = 8'(i + 2);
            tick();
        end
        in_valid = 1'b0;
        #2;
        nreset = 1'b0;
        #1;
        check("async_reset", {in_ready, out_valid, busy, out_sum, out_count}, 0);
        nreset = 1'b1;
        tick();
        check("post_reset_idle", {busy, out_valid}, 0);
        begin_txn(tbl[5]);
        wait_done(tbl[5]);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_accum.md
# csa_accum

Multi-operand carry-save accumulator controller built around the 4:2 carry-save compressor. It accepts a stream of operand pairs over a valid/ready handshake and folds each pair into a registered sum/carry vector pair with one 4:2 compression per beat. On the last beat it resolves the redundant form with a carry-propagate add and presents the result on an output handshake. It sits between operand producers (e.g. partial-product generators, dot-product lanes) and any consumer that needs a binary sum.

## Interface
- DW, 8: operand and result width; arithmetic is modulo 2^DW.
- CW, 8: width of the beat counter.
- clk  input  1  clock, rising edge.
- nreset  input  1  asynchronous active-low reset.
- start  input  1  begin a new accumulation; honoured only in IDLE.
- clear  input  1  synchronous abort to IDLE from any state.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts a pair this cycle.
- in_a  input  DW  operand A.
- in_b  input  DW  operand B (drive 0 for an odd operand count).
- in_last  input  1  marks the final pair of the accumulation.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  DW  (sum of all accepted in_a + in_b) mod 2^DW.
- out_count  output  CW  accepted beats, saturating at 2^CW-1.
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCUM, RESOLVE, DONE.
- IDLE: in_ready=0, out_valid=0. start=1 -> clear S, C, count to 0; go to ACCUM.
- ACCUM: in_ready=1. On in_valid&in_ready: compress (S, C, in_a, in_b) with cin=0; S <= sum; C <= {carry[DW-2:0],1'b0}; bits of weight >= 2^DW are discarded. count increments, holding at 2^CW-1. If in_last=1 on that beat, go to RESOLVE.
- RESOLVE: out_sum register <= S + C (DW-bit, wraps); go to DONE (see Configuration for split mode).
- DONE: out_valid=1, out_sum/out_count stable. out_ready=1 -> IDLE.
- clear=1: next state IDLE, S/C/count zeroed, outputs to reset values; clear overrides every simultaneous event (handshake, start, in_last).
- start outside IDLE is ignored; in_valid outside ACCUM is ignored and not counted.
- An accumulation with zero beats is impossible; the first accepted beat may carry in_last.

## Timing
- Reset (nreset=0, asynchronous): state IDLE, in_ready=0, out_valid=0, out_sum=0, out_count=0, busy=0, S=C=0.
- start in cycle t -> in_ready=1 from cycle t+1.
- Throughput: one pair per cycle while in_valid=1 in ACCUM; no bubbles.
- Last beat accepted at cycle t -> RESOLVE at t+1 -> out_valid=1 at t+2 (t+3 in split mode).
- out_valid&out_ready at cycle t -> IDLE at t+1; start accepted no earlier than t+1.
- in_ready is a registered state decode; no combinational path from in_valid to in_ready or from out_ready to out_valid.
- Reset asserted mid-operation discards all state immediately; no partial result is emitted.

## Configuration
- CSA_ACCUM_SPLIT_EN defined: RESOLVE takes two cycles; cycle 1 adds low DW/2 bits and registers the carry, cycle 2 adds high DW/2 bits with that carry. DW must be even. Shortens the final-adder critical path.
- Not defined: single-cycle full-width DW-bit add in RESOLVE.
- out_sum value is identical in both modes; only latency differs.

## Test plan
- DW=8: start; beats (3,5),(10,20,last) -> out_valid two cycles after last beat (three with split), out_sum=38, out_count=2.
- Wrap: beat (200,100,last) -> out_sum=44; beats (255,255),(255,255),(4,0,last) -> out_sum=0 (1024 mod 256).
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid, out_sum, out_count stable; in_ready=0, in_valid pulses ignored; start ignored until out_ready handshake, then IDLE.
- Count saturation, CW=2: 5 beats of (1,1) -> out_sum=10, out_count=3.
- Abort: clear asserted on the same cycle as a last beat -> IDLE next cycle, no out_valid; fresh run (7,0,last) -> out_sum=7, out_count=1.
- Async reset mid-ACCUM after 3 beats -> all outputs 0 immediately; after release, a fresh run (9,9,last) returns 18.
